dlfloat_operand_sequencer: RTL and testbench
============================================

// Module: dlfloat_operand_sequencer
// PURPOSE
//  Upstream stage of dlfloat_mac. Pairs a 16-bit DLFloat word stream (A then B) into operand pairs,
//  buffers them in a small FIFO and issues one pair per cycle under valid/ready.
//  Tracks MAC pipeline latency so res_valid marks the cycle the matching accumulated result is at the MAC output.
// PARAMETERS
//  DEPTH    4  operand-pair FIFO entries; power of 2, >=2
//  MAC_LAT  3  cycles from issue (op_valid&&op_ready) to result valid at MAC output; >=1
//  CNT_W    8  width of issued-pair counter
// PORTS
//  clk       in   1      clock, all state on rising edge
//  rst_n     in   1      asynchronous reset, active low
//  data_in   in   16     DLFloat word; A when phase=0, B when phase=1
//  in_valid  in   1      data_in valid
//  in_ready  out  1      sequencer accepts data_in this cycle
//  clr       in   1      synchronous flush, priority over all other events
//  op_a      out  16     head-of-FIFO operand A to MAC
//  op_b      out  16     head-of-FIFO operand B to MAC
//  op_valid  out  1      head pair valid
//  op_ready  in   1      MAC consumes head pair this cycle
//  res_valid out  1      MAC result for an issued pair valid this cycle
//  phase     out  1      0 = next accepted word is A, 1 = next is B
//  pair_cnt  out  CNT_W  pairs issued since reset/clr, saturating
// BEHAVIOUR
//  Reset (rst_n=0, async): phase=0, FIFO empty (count=0, pointers 0), a_hold=0, latency pipe=0, pair_cnt=0.
//   Outputs under reset: op_valid=0, op_a=op_b=0, res_valid=0; in_ready=0 while rst_n=0, 1 first cycle after.
//  Accept = in_valid && in_ready; in_ready = (count != DEPTH) && !clr (registered count, no same-cycle pop bypass).
//  Pairing FSM, two states:
//   S_A (phase=0): accept -> a_hold <= data_in, go S_B. No FIFO write.
//   S_B (phase=1): accept -> write {a_hold, data_in} at wr_ptr, wr_ptr+1 mod DEPTH, go S_A.
//   No accept -> state holds; a_hold held indefinitely across stalls.
//  FIFO: count in 0..DEPTH (width clog2(DEPTH)+1). Push only in S_B accept; pop = op_valid && op_ready.
//   Push+pop same cycle: count unchanged, both pointers advance. Pointers wrap DEPTH-1 -> 0.
//   Full: in_ready=0 in both states (A not accepted either). Empty: op_valid=0, pop ignored.
//  Output: op_valid = (count!=0); op_a/op_b = head entry combinationally, forced 16'h0000 when empty
//   (MAC multiplier yields 0 for zero operand; accumulator unaffected).
//  Latency tracking: MAC_LAT-bit shift reg, bit0 <= pop, shifts each cycle; res_valid = last bit.
//   Issue at cycle t -> res_valid=1 at cycle t+MAC_LAT exactly; back-to-back issues -> back-to-back res_valid.
//  pair_cnt: +1 per pop, saturates at 2**CNT_W-1, no wrap.
//  clr=1: next edge empties FIFO, pointers 0, phase=0, a_hold=0, latency pipe=0, pair_cnt=0;
//   concurrent accept/pop discarded (in_ready forced 0; pop not counted). Partial A pair discarded.
//  Reset mid-operation: immediate return to reset values regardless of state, no pending res_valid.
//  No arithmetic on operand data; words passed bit-exact.
// TESTING
//  Push A=16'h3E00,B=16'h4000, op_ready=1 -> op_valid 1 cycle after B, op_a=3E00 op_b=4000, res_valid MAC_LAT cycles after issue.
//  op_ready=0, push 5 pairs (DEPTH=4) -> in_ready=0 after 4th pair; 5th A stalls; drain -> order preserved 1..5.
//  Full FIFO, op_ready=1 and in_valid=1 in S_B -> no push that cycle (in_ready=0), count 4->3, next cycle push accepted.
//  Accept A=16'h1234, assert clr next cycle -> phase=0, op_valid=0, pair_cnt=0, no res_valid from pre-clr pairs.
//  Continuous pairs with op_ready toggling 1/0 -> pair_cnt equals number of res_valid pulses; saturates at 255.
//  Assert rst_n=0 mid-drain with 3 pairs queued and 2 in flight -> op_valid=0, res_valid=0 immediately, in_ready=1 after release.

Source files
------------

// File: rtl/dlfloat_operand_sequencer.sv
// Pairs a DLFloat word stream (A then B) into operand pairs, queues them in a small FIFO
// and issues one pair per cycle to dlfloat_mac, tracking MAC latency for res_valid.
module dlfloat_operand_sequencer #(
    parameter int DEPTH   = 4,
    parameter int MAC_LAT = 3,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      data_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             clr,
    output logic [15:0]      op_a,
    output logic [15:0]      op_b,
    output logic             op_valid,
    input  logic             op_ready,
    output logic             res_valid,
    output logic             phase,
    output logic [CNT_W-1:0] pair_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [0:0] S_A = 1'b0;
    localparam logic [0:0] S_B = 1'b1;

    logic [0:0]         state;
    logic [CW-1:0]      count;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [15:0]        a_hold;
    logic [31:0]        mem [DEPTH];
    logic [MAC_LAT-1:0] lat_pipe;

    logic accept;
    logic push;
    logic pop;

    // rst_n gates in_ready so nothing is advertised while the block is held in reset.
    assign in_ready = rst_n && (count != CW'(DEPTH)) && !clr;
    assign accept   = in_valid && in_ready;
    assign push     = accept && (state == S_B);
    assign op_valid = (count != '0);
    assign pop      = op_valid && op_ready && !clr;

    assign op_a      = op_valid ? mem[rd_ptr][31:16] : '0;
    assign op_b      = op_valid ? mem[rd_ptr][15:0]  : '0;
    assign res_valid = lat_pipe[MAC_LAT-1];
    assign phase     = state[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_A;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            a_hold   <= '0;
            lat_pipe <= '0;
            pair_cnt <= '0;
        end else if (clr) begin
            state    <= S_A;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            a_hold   <= '0;
            lat_pipe <= '0;
            pair_cnt <= '0;
        end else begin
            if (accept) begin
                if (state == S_A) begin
                    a_hold <= data_in;
                    state  <= S_B;
                end else begin
                    state  <= S_A;
                end
            end

            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);

            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            lat_pipe[0] <= pop;
            for (int unsigned i = 1; i < MAC_LAT; i++) begin
                lat_pipe[i] <= lat_pipe[i-1];
            end

            if (pop && (pair_cnt != '1)) pair_cnt <= pair_cnt + CNT_W'(1);
        end
    end

    // Storage needs no reset: op_a/op_b are masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {a_hold, data_in};
    end

endmodule

// File: tb/tb_dlfloat_operand_sequencer.sv
// Directed self-checking bench for dlfloat_operand_sequencer (DEPTH=4, MAC_LAT=3, CNT_W=8).
module tb_dlfloat_operand_sequencer;

    logic        clk;
    logic        rst_n;
    logic [15:0] data_in;
    logic        in_valid;
    logic        in_ready;
    logic        clr;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        op_valid;
    logic        op_ready;
    logic        res_valid;
    logic        phase;
    logic [7:0]  pair_cnt;

    int checks   = 0;
    int failures = 0;
    int rv_cnt   = 0;
    int pop_cnt  = 0;

    dlfloat_operand_sequencer #(
        .DEPTH  (4),
        .MAC_LAT(3),
        .CNT_W  (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .clr      (clr),
        .op_a     (op_a),
        .op_b     (op_b),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .res_valid(res_valid),
        .phase    (phase),
        .pair_cnt (pair_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent observation of issue handshakes and result pulses.
    always @(negedge clk) begin
        if (res_valid) rv_cnt++;
        if (rst_n && op_valid && op_ready && !clr) pop_cnt++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [15:0] w);
        data_in  = w;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic push_pair(input logic [15:0] a, input logic [15:0] b);
        push_word(a);
        push_word(b);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) cyc();
        checks++; if (op_valid !== 1'b0) begin failures++; $display("FAIL rst_op_valid got=%b exp=0", op_valid); end
        checks++; if (op_a !== 16'h0000 || op_b !== 16'h0000) begin failures++; $display("FAIL rst_ops got=%h/%h exp=0000/0000", op_a, op_b); end
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL rst_res_valid got=%b exp=0", res_valid); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready_low got=%b exp=0", in_ready); end
        checks++; if (phase !== 1'b0 || pair_cnt !== 8'd0) begin failures++; $display("FAIL rst_state got phase=%b cnt=%0d exp 0/0", phase, pair_cnt); end
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready_after got=%b exp=1", in_ready); end
        cyc();
    endtask

    task automatic test_single();
        op_ready = 1'b1;
        push_pair(16'h3E00, 16'h4000);
        checks++; if (op_valid !== 1'b1 || op_a !== 16'h3E00 || op_b !== 16'h4000) begin
            failures++; $display("FAIL single_head got v=%b a=%h b=%h exp 1/3e00/4000", op_valid, op_a, op_b); end
        checks++; if (phase !== 1'b0) begin failures++; $display("FAIL single_phase got=%b exp=0", phase); end
        cyc();
        checks++; if (op_valid !== 1'b0 || pair_cnt !== 8'd1) begin
            failures++; $display("FAIL single_issue got v=%b cnt=%0d exp 0/1", op_valid, pair_cnt); end
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL single_rv_early1 got=%b exp=0", res_valid); end
        cyc();
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL single_rv_early2 got=%b exp=0", res_valid); end
        cyc();
        checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL single_rv_at_lat got=%b exp=1", res_valid); end
        cyc();
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL single_rv_after got=%b exp=0", res_valid); end
        op_ready = 1'b0;
    endtask

    task automatic test_fill_order();
        op_ready = 1'b0;
        for (int k = 1; k <= 4; k++) push_pair(16'(k), 16'h0100 | 16'(k));
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
        checks++; if (op_a !== 16'h0001 || op_b !== 16'h0101) begin failures++; $display("FAIL full_head got=%h/%h exp=0001/0101", op_a, op_b); end
        data_in  = 16'h0005;
        in_valid = 1'b1;
        cyc();
        checks++; if (phase !== 1'b0) begin failures++; $display("FAIL full_a_stall phase got=%b exp=0", phase); end
        op_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_pop_cycle in_ready got=%b exp=0", in_ready); end
        cyc();
        checks++; if (op_a !== 16'h0002 || phase !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL full_after_pop got a=%h ph=%b rdy=%b exp 0002/0/1", op_a, phase, in_ready); end
        op_ready = 1'b0;
        cyc();
        checks++; if (phase !== 1'b1) begin failures++; $display("FAIL full_a_accept phase got=%b exp=1", phase); end
        push_word(16'h0105);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL refill in_ready got=%b exp=0", in_ready); end
        op_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            checks++; if (op_valid !== 1'b1 || op_a !== 16'(k) || op_b !== (16'h0100 | 16'(k))) begin
                failures++; $display("FAIL drain_order k=%0d got v=%b a=%h b=%h", k, op_valid, op_a, op_b); end
            cyc();
        end
        checks++; if (op_valid !== 1'b0 || op_a !== 16'h0000) begin failures++; $display("FAIL drain_empty got v=%b a=%h exp 0/0000", op_valid, op_a); end
        op_ready = 1'b0;
        repeat (4) cyc();
        checks++; if (pair_cnt !== 8'd6) begin failures++; $display("FAIL fill_pair_cnt got=%0d exp=6", pair_cnt); end
    endtask

    task automatic test_clr();
        int rv0;
        op_ready = 1'b0;
        push_pair(16'hAAAA, 16'hBBBB);
        push_pair(16'hCCCC, 16'hDDDD);
        push_word(16'h1234);
        op_ready = 1'b1;
        cyc();
        clr = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL clr_in_ready got=%b exp=0", in_ready); end
        cyc();
        clr = 1'b0;
        op_ready = 1'b0;
        rv0 = rv_cnt;
        checks++; if (phase !== 1'b0 || op_valid !== 1'b0 || op_a !== 16'h0000) begin
            failures++; $display("FAIL clr_state got ph=%b v=%b a=%h exp 0/0/0000", phase, op_valid, op_a); end
        checks++; if (pair_cnt !== 8'd0) begin failures++; $display("FAIL clr_pair_cnt got=%0d exp=0", pair_cnt); end
        repeat (6) cyc();
        checks++; if (rv_cnt - rv0 !== 0) begin failures++; $display("FAIL clr_no_res_valid got=%0d pulses exp=0", rv_cnt - rv0); end
    endtask

    task automatic test_toggle_sat();
        int rv0, pc0;
        logic acc;
        rv0 = rv_cnt;
        pc0 = pop_cnt;
        data_in  = 16'h0000;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            op_ready = i[0];
            #1;
            acc = in_ready;
            cyc();
            if (acc) data_in = data_in + 16'd1;
        end
        in_valid = 1'b0;
        op_ready = 1'b1;
        repeat (10) cyc();
        checks++; if (int'(pair_cnt) !== pop_cnt - pc0 || pop_cnt - pc0 == 0) begin
            failures++; $display("FAIL toggle_pair_cnt got=%0d exp=%0d", pair_cnt, pop_cnt - pc0); end
        checks++; if (rv_cnt - rv0 !== int'(pair_cnt)) begin
            failures++; $display("FAIL toggle_res_pulses got=%0d exp=%0d", rv_cnt - rv0, pair_cnt); end
        in_valid = 1'b1;
        for (int i = 0; i < 700; i++) begin
            #1;
            acc = in_ready;
            cyc();
            if (acc) data_in = data_in + 16'd1;
        end
        in_valid = 1'b0;
        repeat (10) cyc();
        checks++; if (pair_cnt !== 8'd255) begin failures++; $display("FAIL sat_pair_cnt got=%0d exp=255", pair_cnt); end
        checks++; if (rv_cnt - rv0 !== pop_cnt - pc0 || pop_cnt - pc0 <= 255) begin
            failures++; $display("FAIL sat_res_pulses got=%0d exp=%0d", rv_cnt - rv0, pop_cnt - pc0); end
        op_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int rv0;
        op_ready = 1'b0;
        for (int k = 1; k <= 4; k++) push_pair(16'h0200 | 16'(k), 16'h0300 | 16'(k));
        op_ready = 1'b1;
        data_in  = 16'h0205;
        in_valid = 1'b1;
        cyc();
        cyc();
        op_ready = 1'b0;
        data_in  = 16'h0305;
        cyc();
        in_valid = 1'b0;
        checks++; if (op_valid !== 1'b1 || res_valid !== 1'b1 || op_a !== 16'h0203) begin
            failures++; $display("FAIL mid_pre_reset got v=%b rv=%b a=%h exp 1/1/0203", op_valid, res_valid, op_a); end
        rst_n = 1'b0;
        #1;
        checks++; if (op_valid !== 1'b0 || res_valid !== 1'b0 || in_ready !== 1'b0) begin
            failures++; $display("FAIL mid_reset_outputs got v=%b rv=%b rdy=%b exp 0/0/0", op_valid, res_valid, in_ready); end
        rst_n = 1'b1;
        #1;
        rv0 = rv_cnt;
        checks++; if (in_ready !== 1'b1 || pair_cnt !== 8'd0 || phase !== 1'b0) begin
            failures++; $display("FAIL mid_release got rdy=%b cnt=%0d ph=%b exp 1/0/0", in_ready, pair_cnt, phase); end
        repeat (5) cyc();
        checks++; if (rv_cnt - rv0 !== 0) begin failures++; $display("FAIL mid_no_pending got=%0d pulses exp=0", rv_cnt - rv0); end
    endtask

    initial begin
        rst_n    = 1'b0;
        data_in  = 16'h0000;
        in_valid = 1'b0;
        clr      = 1'b0;
        op_ready = 1'b0;
        test_reset();
        test_single();
        test_fill_order();
        test_clr();
        test_toggle_sat();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
